// File: rtl/crypto_pkg.sv
// Shared constants for the cryptosystem datapath: keystream modes and the
// default Galois LFSR configuration.
package crypto_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  localparam int          DEF_LFSR_W    = 16;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;

  // All-zero is a lock-up state for the LFSR, so a zero seed is replaced.
  localparam int SEED_ZERO_SUB = 1;

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with step enable and seed load; a zero seed is substituted so
// the register can never lock up.
module lfsr_galois
  import crypto_pkg::*;
#(
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DEF_LFSR_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] SUB = LFSR_W'(SEED_ZERO_SUB);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SUB;
    else if (load)
      state <= (seed == '0) ? SUB : seed;
    else if (step)
      state <= (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: one registered output stage, static or LFSR keystream,
// valid/ready on both sides with full throughput.
module xor_stream_cipher
  import crypto_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DEF_LFSR_POLY),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  word_count
);

  if (DATA_W < 1 || DATA_W > LFSR_W) begin : g_bad_width
    $error("xor_stream_cipher: DATA_W must be in 1..LFSR_W");
  end

  logic [DATA_W-1:0] key_r;
  logic [LFSR_W-1:0] lfsr_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  word_count_r;
  logic [DATA_W-1:0] ks;
  logic              acc;

  // in_ready is not gated by key_load; the source holds the word across it.
  assign in_ready = ~out_valid_r | out_ready;
  assign acc      = in_valid & in_ready & ~key_load;
  assign ks       = (mode == MODE_LFSR) ? (key_r ^ lfsr_r[DATA_W-1:0]) : key_r;

  lfsr_galois #(
    .LFSR_W   (LFSR_W),
    .LFSR_POLY(LFSR_POLY)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (key_load),
    .seed (seed_in),
    .step (acc & (mode == MODE_LFSR)),
    .state(lfsr_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_r        <= '0;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      word_count_r <= '0;
    end else begin
      if (key_load) begin
        key_r        <= key_in;
        word_count_r <= '0;
      end else if (acc) begin
        word_count_r <= word_count_r + CNT_W'(1);
      end
      // A pending output is left alone by key_load and completes under its old key.
      if (acc) begin
        out_data_r  <= in_data ^ ks;
        out_valid_r <= 1'b1;
      end else if (out_valid_r & out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Scoreboard bench for xor_stream_cipher: expected words are queued at accept
// time and compared when the output handshake completes.
module tb_xor_stream_cipher;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        key_load;
  logic [7:0]  key_in;
  logic [15:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[$];
  logic [7:0]  m_key;
  logic [15:0] m_lfsr;
  logic [15:0] m_cnt;
  int          pushed = 0;
  int          popped = 0;

  always #5 clk = ~clk;

  xor_stream_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key_load  (key_load),
    .key_in    (key_in),
    .seed_in   (seed_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_count(word_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        popped++;
      end
    end
  end

  task automatic do_key_load(input logic [7:0] k, input logic [15:0] s);
    key_load = 1'b1;
    key_in   = k;
    seed_in  = s;
    @(posedge clk); #1;
    key_load = 1'b0;
    m_key  = k;
    m_lfsr = (s == 16'h0) ? 16'h0001 : s;
    m_cnt  = '0;
  endtask

  // Holds the word until it is accepted; the bench model supplies the expected
  // result unless use_exp forces a known answer (e.g. a decrypt).
  task automatic send(input logic [7:0] d, input logic m, input bit use_exp,
                      input logic [7:0] e, output logic [7:0] res);
    logic [7:0] ks;
    bit done;
    done     = 1'b0;
    res      = '0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ks  = m ? (m_key ^ m_lfsr[7:0]) : m_key;
        res = d ^ ks;
        sb.push_back(use_exp ? e : res);
        pushed++;
        if (m) m_lfsr = lfsr_step(m_lfsr);
        m_cnt++;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [7:0]  pt[16];
    logic [7:0]  ct[16];
    logic [7:0]  held;
    logic [15:0] held_lfsr;
    logic [15:0] held_cnt;

    rst = 1'b1; mode = 1'b0; key_load = 1'b0; key_in = '0; seed_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_key = '0; m_lfsr = 16'h0001; m_cnt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_lfsr", dut.lfsr_r, 16'h0001);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // static key round trip
    do_key_load(8'h5A, 16'h0001);
    send(8'h3C, 1'b0, 1'b1, 8'h66, r);
    @(negedge clk);
    chk("static_count1", word_count, 16'd1);
    @(posedge clk); #1;
    send(8'h66, 1'b0, 1'b1, 8'h3C, r);
    drain();

    // LFSR keystream from seed 1
    do_key_load(8'h00, 16'h0001);
    chk("lfsr_seed", dut.lfsr_r, 16'h0001);
    send(8'h00, 1'b1, 1'b1, 8'h01, r);
    chk("lfsr_1", dut.lfsr_r, 16'hB400);
    send(8'h00, 1'b1, 1'b1, 8'h00, r);
    chk("lfsr_2", dut.lfsr_r, 16'h5A00);
    send(8'h00, 1'b1, 1'b1, 8'h00, r);
    chk("lfsr_3", dut.lfsr_r, 16'h2D00);
    drain();
    chk("lfsr_count", word_count, 16'd3);

    // encrypt/decrypt round trip, back-to-back
    do_key_load(8'hA5, 16'hACE1);
    for (int i = 0; i < 16; i++) begin
      pt[i] = 8'($urandom_range(0, 255));
      send(pt[i], 1'b1, 1'b0, 8'h00, ct[i]);
    end
    drain();
    chk("rt_count", word_count, m_cnt);
    chk("rt_lfsr_model", dut.lfsr_r, m_lfsr);
    do_key_load(8'hA5, 16'hACE1);
    for (int i = 0; i < 16; i++) send(ct[i], 1'b1, 1'b1, pt[i], r);
    drain();

    // backpressure: output held, upstream stalled, state frozen
    out_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 8'h00, r);
    in_valid = 1'b1; in_data = 8'h22; mode = 1'b1;
    @(negedge clk);
    held = out_data; held_lfsr = dut.lfsr_r; held_cnt = word_count;
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data", out_data, held);
      chk("bp_lfsr", dut.lfsr_r, held_lfsr);
      chk("bp_count", word_count, held_cnt);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h22, 1'b1, 1'b0, 8'h00, r);
    send(8'h33, 1'b1, 1'b0, 8'h00, r);
    drain();
    chk("bp_no_loss", popped, pushed);
    chk("bp_count_after", word_count, m_cnt);

    // zero seed is substituted by 1
    do_key_load(8'h00, 16'h0000);
    chk("seed0_lfsr", dut.lfsr_r, 16'h0001);
    send(8'h00, 1'b1, 1'b1, 8'h01, r);
    drain();

    // reset mid-stream drops the pending output
    out_ready = 1'b0;
    send(8'h44, 1'b1, 1'b0, 8'h00, r);
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    chk("mid_out_valid_pre", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", word_count, 0);
    chk("mid_rst_lfsr", dut.lfsr_r, 16'h0001);
    chk("mid_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
